dlx_fetch_stage: RTL



---
 rtl/dlx_pkg.sv | 33 +++
 rtl/dlx_fetch_stage_if.sv | 14 +
 rtl/fetch_hold_buf.sv | 33 +++
 rtl/dlx_fetch_stage.sv | 131 +++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Purpose : shared DLX constants, opcodes and fetch-stage types.
// Latency : n/a (package only).
// Backpressure: n/a.
package dlx_pkg;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Opcodes produced/consumed by the decode-stage jump/branch resolver.
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h12;

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  // Instruction word paired with its fall-through PC.
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc4;
  } fetch_word_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
    logic [31:0] pc4;
  } if_id_t;

endpackage

// File: rtl/dlx_fetch_stage_if.sv
// Purpose : instruction-memory request/response bundle.
// Ports   : imem_req/imem_addr (fetch -> mem), imem_ready/imem_rdata (mem -> fetch).
// Backpressure: single outstanding request; imem_addr held until imem_ready.
interface dlx_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// Purpose : 1-entry 64-bit skid buffer parking a fetched word while decode stalls.
// Latency : load visible on data_o/valid_o one edge after load_i.
// Backpressure: none internally; clear_i wins over load_i.
// Ports   : clk, reset, load_i, clear_i, data_i[63:0], data_o[63:0], valid_o.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic        valid_o
);

  logic        valid_q;
  logic [63:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/dlx_fetch_stage.sv
// Purpose : DLX instruction fetch: PC, single-outstanding imem request, IF/ID register.
// Latency : IF/ID loads 1 edge after imem_ready; 1 bubble per taken redirect.
// Backpressure: stall parks one word in the hold buffer and stops requesting.
// Ports   : clk, reset, imem (master modport), redirect_i, redirect_pc_i, stall_i,
//           if_id_valid_o, if_id_instruction_o, if_id_pc_plus_four_o.
module dlx_fetch_stage
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  dlx_fetch_stage_if.master         imem,
  input  logic                      redirect_i,
  input  logic [31:0]               redirect_pc_i,
  input  logic                      stall_i,
  output logic                      if_id_valid_o,
  output logic [31:0]               if_id_instruction_o,
  output logic [31:0]               if_id_pc_plus_four_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         drop_q, drop_d;
  logic         req_q;
  if_id_t       ifid_q, ifid_d;

  logic         hold_load, hold_clear, hold_vld;
  fetch_word_t  hold_word, hold_in;

  logic         fire;
  logic [31:0]  target;
  logic [31:0]  seq_pc;

  // req_q is a register so imem_req never depends combinationally on redirect/stall.
  assign fire   = req_q & imem.imem_ready;
  assign target = redirect_pc_i & ~32'h3;
  assign seq_pc = req_addr_q + 32'd4;

  assign hold_in.insn = imem.imem_rdata;
  assign hold_in.pc4  = seq_pc;

  fetch_hold_buf u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .data_i  (hold_in),
    .data_o  (hold_word),
    .valid_o (hold_vld)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    ifid_d     = ifid_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;

    if (redirect_i) begin
      ifid_d     = '{valid: 1'b0, insn: NOP_INSN, pc4: target};
      pc_d       = target;
      hold_clear = 1'b1;
      state_d    = REQ;
      // An unanswered request is still in flight: keep its address stable and
      // throw its data away when it finally returns.
      if (state_q == REQ && req_q && !imem.imem_ready) begin
        drop_d = 1'b1;
      end else begin
        req_addr_d = target;
        drop_d     = 1'b0;
      end
    end else begin
      case (state_q)
        REQ: begin
          if (fire) begin
            if (drop_q) begin
              drop_d     = 1'b0;
              req_addr_d = pc_q;
            end else if (!stall_i || !ifid_q.valid) begin
              ifid_d     = '{valid: 1'b1, insn: imem.imem_rdata, pc4: seq_pc};
              pc_d       = seq_pc;
              req_addr_d = seq_pc;
            end else begin
              hold_load = 1'b1;
              pc_d      = seq_pc;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i && hold_vld) begin
            ifid_d     = '{valid: 1'b1, insn: hold_word.insn, pc4: hold_word.pc4};
            req_addr_d = pc_q;
            hold_clear = 1'b1;
            state_d    = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
      ifid_q     <= '{valid: 1'b0, insn: NOP_INSN, pc4: RESET_PC + 32'd4};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      req_q      <= (state_d == REQ);
      ifid_q     <= ifid_d;
    end
  end

  assign imem.imem_req        = req_q;
  assign imem.imem_addr       = req_addr_q;
  assign if_id_valid_o        = ifid_q.valid;
  assign if_id_instruction_o  = ifid_q.insn;
  assign if_id_pc_plus_four_o = ifid_q.pc4;

endmodule
